// File: rtl/serial_logic_pkg.sv
// Shared definitions for the serial logic engine.
// Holds the FSM state encoding and the named 4-bit truth-table codes
// understood by the per-bit logicalunit (out = func[{a,b}]).
package serial_logic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] FUNC_NOR    = 4'b0001;
    localparam logic [3:0] FUNC_XOR    = 4'b0110;
    localparam logic [3:0] FUNC_NAND   = 4'b0111;
    localparam logic [3:0] FUNC_AND    = 4'b1000;
    localparam logic [3:0] FUNC_XNOR   = 4'b1001;
    localparam logic [3:0] FUNC_PASS_B = 4'b1010;
    localparam logic [3:0] FUNC_PASS_A = 4'b1100;
    localparam logic [3:0] FUNC_OR     = 4'b1110;

endpackage

// File: rtl/logicalunit.sv
// Two-input programmable logic cell.
// Ports: a, b - operand bits; func[3:0] - truth table; out = func[{a,b}].
module logicalunit (
    input  logic       a,
    input  logic       b,
    input  logic [3:0] func,
    output logic       out
);

    assign out = func[{a, b}];

endmodule

// File: rtl/serial_logic_engine.sv
// Bit-serial sequencer around one logicalunit.
// Accepts an operand pair and function code (in_valid/in_ready), streams
// the operands LSB-first through the cell one bit per clock, rebuilds the
// result word and offers it on out_valid/out_ready.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid, in_ready    - input handshake (ready only in IDLE)
//   op_a, op_b, func      - operands and truth table, sampled at accept
//   out_valid, out_ready  - output handshake (valid only in DONE)
//   result                - assembled result word
//   busy                  - operation in progress or result pending
module serial_logic_engine
    import serial_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    // Counter must exist even for WIDTH=1.
    localparam int CNT_W = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   sh_a_r;
    logic [WIDTH-1:0]   sh_b_r;
    logic [3:0]         func_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   result_shift_s;
    logic               lu_out_s;
    logic               accept_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    // Single per-bit datapath cell, fed from the low end of the shifters.
    logicalunit u_lu (
        .a    (sh_a_r[0]),
        .b    (sh_b_r[0]),
        .func (func_r),
        .out  (lu_out_s)
    );

    // Handshake qualifiers are taken from the state register, not from outputs.
    always_comb begin
        accept_s = in_valid && (state_r == ST_IDLE);
    end

    // Next-state decode; any unknown encoding falls back to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // New result bit enters at the MSB so the first (LSB) step ends at bit 0.
    always_comb begin
        result_shift_s             = result_r >> 1;
        result_shift_s[WIDTH-1]    = lu_out_s;
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    // Operand capture, serial shifting, bit counting and result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= '0;
            sh_a_r   <= '0;
            sh_b_r   <= '0;
            func_r   <= 4'b0000;
            result_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        sh_a_r <= op_a;
                        sh_b_r <= op_b;
                        func_r <= func;
                        cnt_r  <= '0;
                    end else begin
                        cnt_r  <= cnt_r;
                    end
                end
                ST_RUN: begin
                    result_r <= result_shift_s;
                    sh_a_r   <= sh_a_r >> 1;
                    sh_b_r   <= sh_b_r >> 1;
                    cnt_r    <= cnt_r + CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;

endmodule
